// File: rtl/vc_arb_pkg.sv
// Shared definitions for the virtual-channel arbiter: FSM encodings,
// word field positions and default configuration.
package vc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        PAUSE   = 2'd2,
        ILLEGAL = 2'd3
    } arb_state_t;

    localparam int DEFAULT_BW         = 6;
    localparam int DEFAULT_STARVE_MAX = 4;
    localparam int DEFAULT_CW         = 3;

    // Field positions for the default word width; both are counted down from the MSB.
    localparam int CLASS_BIT = DEFAULT_BW - 1;
    localparam int DEST_BIT  = DEFAULT_BW - 2;

endpackage

// File: rtl/vc_grant_sel.sv
// Strict-priority VC0/VC1 grant with a starvation counter that forces one
// VC1 grant after STARVE_MAX consecutive VC0 grants.
module vc_grant_sel
    import vc_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX,
    parameter int CW         = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          grant_en,
    input  logic          vc0_empty,
    input  logic          vc1_empty,
    output logic          gnt0,
    output logic          gnt1,
    output logic [CW-1:0] starve_cnt
);

    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic starved;

    assign starved = (starve_cnt == CNT_MAX);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (grant_en) begin
            if (!vc0_empty && !vc1_empty && starved) begin
                gnt1 = 1'b1;
            end else if (!vc0_empty) begin
                gnt0 = 1'b1;
            end else if (!vc1_empty) begin
                gnt1 = 1'b1;
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            starve_cnt <= '0;
        end else if (vc1_empty || gnt1) begin
            starve_cnt <= '0;
        end else if (gnt0 && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vc_arbiter.sv
// VC0/VC1 to D0/D1 arbiter: priority pops, two-stage read pipeline, steering
// on the destination bit, and pause while either destination is almost full.
// Optional grant counters are enabled with the VC_ARB_STATS_EN macro.
module vc_arbiter
    import vc_arb_pkg::*;
#(
    parameter int BW         = DEFAULT_BW,
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX,
    parameter int CW         = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          VC0_empty,
    input  logic          VC1_empty,
    input  logic [BW-1:0] VC0_data_out,
    input  logic [BW-1:0] VC1_data_out,
    input  logic          D0_almost_full,
    input  logic          D1_almost_full,
    output logic          VC0_rd,
    output logic          VC1_rd,
    output logic          D0_push,
    output logic          D1_push,
    output logic [BW-1:0] data_out,
    output logic [1:0]    arb_state
`ifdef VC_ARB_STATS_EN
    ,
    output logic [15:0]   VC0_grant_cnt,
    output logic [15:0]   VC1_grant_cnt
`endif
);

    // Destination bit keeps its distance from the MSB when BW is overridden.
    localparam int DEST_IDX = BW - (DEFAULT_BW - DEST_BIT);

    arb_state_t    state;
    arb_state_t    next_state;
    logic          hold;
    logic          any_ready;
    logic          grant_en;
    logic          gnt0;
    logic          gnt1;
    logic [CW-1:0] starve_cnt;
    logic          rd0_q;
    logic          rd1_q;
    logic          cap_valid;
    logic [BW-1:0] cap_word;

    assign hold      = D0_almost_full | D1_almost_full;
    assign any_ready = !VC0_empty || !VC1_empty;
    assign grant_en  = (state == ACTIVE) && !hold;

    vc_grant_sel #(
        .STARVE_MAX (STARVE_MAX),
        .CW         (CW)
    ) u_grant_sel (
        .clk        (clk),
        .reset_L    (reset_L),
        .grant_en   (grant_en),
        .vc0_empty  (VC0_empty),
        .vc1_empty  (VC1_empty),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .starve_cnt (starve_cnt)
    );

    assign VC0_rd    = gnt0;
    assign VC1_rd    = gnt1;
    assign arb_state = state;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (hold) begin
                    next_state = PAUSE;
                end else if (any_ready) begin
                    next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (hold) begin
                    next_state = PAUSE;
                end else if (any_ready) begin
                    next_state = ACTIVE;
                end
            end
            PAUSE: begin
                // Stay paused for as long as a destination is almost full.
                if (hold) begin
                    next_state = PAUSE;
                end else if (any_ready) begin
                    next_state = ACTIVE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Read data arrives one cycle after the strobe; only one channel is read per cycle.
    assign cap_valid = rd0_q | rd1_q;
    assign cap_word  = rd0_q ? VC0_data_out : VC1_data_out;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd0_q    <= 1'b0;
            rd1_q    <= 1'b0;
            data_out <= '0;
            D0_push  <= 1'b0;
            D1_push  <= 1'b0;
        end else begin
            rd0_q   <= gnt0;
            rd1_q   <= gnt1;
            D0_push <= 1'b0;
            D1_push <= 1'b0;
            if (cap_valid) begin
                data_out <= cap_word;
                D0_push  <= !cap_word[DEST_IDX];
                D1_push  <= cap_word[DEST_IDX];
            end
        end
    end

`ifdef VC_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            VC0_grant_cnt <= '0;
            VC1_grant_cnt <= '0;
        end else begin
            if (gnt0) begin
                VC0_grant_cnt <= VC0_grant_cnt + 16'd1;
            end
            if (gnt1) begin
                VC1_grant_cnt <= VC1_grant_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Stage directly downstream of the VC0/VC1 virtual-channel FIFOs.
- Pops words from the two VC FIFOs under strict priority (VC0 high) with a starvation guard for VC1.
- Steers each popped word to destination FIFO D0 or D1 according to its destination bit.
- Throttles all reads while either destination FIFO is almost full.

Parameters:
- BW, 6, data width; bit BW-1 = class bit, bit BW-2 = destination bit.
- STARVE_MAX, 4, max consecutive VC0 grants while VC1 is non-empty before one forced VC1 grant.
- CW, 3, starvation counter width; must satisfy 2^CW > STARVE_MAX.

Ports:
- clk  in  1  system clock
- reset_L  in  1  asynchronous active-low reset
- VC0_empty  in  1  VC0 FIFO empty
- VC1_empty  in  1  VC1 FIFO empty
- VC0_data_out  in  BW  VC0 FIFO read data, valid the cycle after VC0_rd
- VC1_data_out  in  BW  VC1 FIFO read data, valid the cycle after VC1_rd
- D0_almost_full  in  1  destination FIFO 0 almost full
- D1_almost_full  in  1  destination FIFO 1 almost full
- VC0_rd  out  1  pop VC0
- VC1_rd  out  1  pop VC1
- D0_push  out  1  write data_out into D0
- D1_push  out  1  write data_out into D1
- data_out  out  BW  registered word to the destination FIFOs
- arb_state  out  2  current FSM state, for debug

Behaviour:
- Single clock; reset is asynchronous and active-low (reset_L).
- While reset_L=0, all outputs and internal registers are 0: rd strobes, pushes, data_out, starvation counter, in-flight flags; arb_state=IDLE.
- Reset mid-operation discards any in-flight word. No push occurs for it after release.
- States: IDLE=0, ACTIVE=1, PAUSE=2. Encoding 3 is illegal and recovers to IDLE next cycle.
- hold = D0_almost_full | D1_almost_full.
- IDLE: no reads.
  - hold=1 -> PAUSE.
  - Else if either VC FIFO is non-empty -> ACTIVE.
- ACTIVE: one read per cycle, combinational from registered state and inputs.
  - Grant VC1 if VC0_empty=0, VC1_empty=0 and starve_cnt==STARVE_MAX.
  - Else grant VC0 if VC0_empty=0.
  - Else grant VC1 if VC1_empty=0.
  - Else no read.
  - hold=1 -> PAUSE with no read this cycle.
  - Both FIFOs empty -> IDLE.
- PAUSE: no reads. Returns to ACTIVE when hold=0 and a FIFO is non-empty, otherwise to IDLE.
- VCx_rd is never asserted while VCx_empty=1.
- starve_cnt:
  - Increments on a VC0 grant while VC1_empty=0.
  - Clears on any VC1 grant, or whenever VC1_empty=1.
  - Saturates at STARVE_MAX.
- Pipeline:
  - Cycle N: VCx_rd asserted.
  - Cycle N+1: VCx_data_out valid; the block captures it into data_out.
  - Cycle N+2: data_out stable, with D0_push if bit BW-2=0 or D1_push if bit BW-2=1.
  - Pushes are single-cycle; D0_push and D1_push are never high together.
  - Back-to-back reads give one push per cycle.
- Backpressure:
  - Up to 2 words can be in flight when hold rises; they are always delivered.
  - Destination almost_full thresholds must leave at least 2 free entries.
- data_out holds its last value when there is no push.

Optional Feature:
- Macro VC_ARB_STATS_EN.
- With the macro: adds outputs VC0_grant_cnt and VC1_grant_cnt, 16 bits each.
  - Each counts rd pulses on its channel and wraps at 2^16.
  - Both clear on reset.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package vc_arb_pkg holds:
  - State encodings IDLE, ACTIVE, PAUSE.
  - Bit indices CLASS_BIT=BW-1 and DEST_BIT=BW-2.
  - Default STARVE_MAX.
- One natural sub-module, vc_grant_sel: combinational grant plus the starvation counter register.
- The FSM, pipeline registers and destination steering stay in vc_arbiter.

Test Plan:
- Reset: hold reset_L=0 with VC0_empty=0 -> VC0_rd=0, pushes=0, data_out=0, arb_state=0; release -> first VC0_rd at the first posedge after release.
- VC0 only: 3 words 0x05, 0x15, 0x25 -> D0_push, D1_push, D0_push on consecutive cycles, 2 cycles after each rd, with matching data_out.
- Starvation: both FIFOs full, STARVE_MAX=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1,... and VC1 is never starved beyond 4.
- Backpressure: D1_almost_full rises while rds are streaming -> no new rd the next cycle; the 2 in-flight words are still pushed; arb_state=2; rds resume 1 cycle after it falls.
- Empty boundary: VC1 holds 1 word and VC0 is empty -> exactly one VC1_rd, then IDLE; no rd while VC1_empty=1.
- Mid-flight reset: assert reset_L=0 the cycle after VC0_rd -> no push is ever produced for that word.
